// File: rtl/alu_pkg.sv
// Shared ALU definitions: data width, opcode encodings and flag bit positions.
package alu_pkg;

    localparam int ALU_DATA_W = 16;
    localparam int FLAG_W     = 3;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_SLT = 3'b111
    } alu_op_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 2;

    // Packs the individual ALU flags into the {overflow, negative, zero} vector.
    function automatic logic [FLAG_W-1:0] pack_flags(input logic v, input logic n, input logic z);
        logic [FLAG_W-1:0] f;
        f         = 3'b000;
        f[FLAG_V] = v;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/alu_result_buffer_if.sv
// Consumer-side valid/ready bus carrying buffered ALU results and flags.
interface alu_result_buffer_if
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [FLAG_W-1:0] out_flags;

    modport master (output out_valid, output out_result, output out_flags, input out_ready);
    modport slave  (input out_valid, input out_result, input out_flags, output out_ready);
endinterface

// File: rtl/alu_result_buffer_chk.sv
// Simulation-only invariants for the result buffer occupancy and credit bookkeeping.
module alu_result_buffer_chk #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input logic         clk,
    input logic         rst_n,
    input logic [PTR_W:0] count,
    input logic [PTR_W:0] reserved,
    input logic         out_valid,
    input logic         pop,
    input logic         drop_err
);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    a_count_max: assert property (@(posedge clk) disable iff (!rst_n) count <= DEPTH_C);
    // Once a protocol violation is flagged the credit accounting no longer reflects the data.
    a_reserved_covers_count: assert property (@(posedge clk) disable iff (!rst_n || drop_err) reserved >= count);
    a_pop_needs_valid: assert property (@(posedge clk) disable iff (!rst_n) pop |-> out_valid);
endmodule

// File: rtl/alu_rsp_mem.sv
// Result storage: register array with one synchronous write port and an asynchronous read port.
module alu_rsp_mem #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Entry contents need no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/alu_result_buffer.sv
// FWFT result buffer behind a stall-free ALU, with credit-based issue throttling.
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int DEPTH  = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_fire,
    input  logic              alu_valid,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_negative,
    input  logic              alu_overflow,
    output logic              credit_ok,
    alu_result_buffer_if.master out_if,
    output logic [PTR_W:0]    count,
    output logic              drop_err,
    input  logic              clr_err
);
    localparam int             ENT_W   = DATA_W + FLAG_W;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_C   = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d, reserved_q, reserved_d;
    logic             drop_err_q, drop_err_d;
    logic             out_valid_s, credit_ok_s, pop_s, full_s, wr_en_s;
    logic             beat_drop_s, issue_ok_s, issue_viol_s;
    logic [ENT_W-1:0] wr_data_s, rd_data_s;

    assign out_valid_s = (count_q != {(PTR_W+1){1'b0}});
    assign credit_ok_s = (reserved_q < DEPTH_C);
    assign wr_data_s   = {pack_flags(alu_overflow, alu_negative, alu_zero), alu_result};

    // Handshake decode, pointer/count/credit next state and sticky error update.
    always_comb begin
        pop_s        = out_valid_s & out_if.out_ready;
        full_s       = (count_q == DEPTH_C);
        wr_en_s      = alu_valid & (~full_s | pop_s);
        beat_drop_s  = alu_valid & full_s & ~pop_s;
        issue_ok_s   = issue_fire & credit_ok_s;
        issue_viol_s = issue_fire & ~credit_ok_s;

        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_en_s, pop_s})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase

        // Credits come back only when the consumer takes an entry.
        case ({issue_ok_s, pop_s})
            2'b10:   reserved_d = reserved_q + ONE_C;
            2'b01:   reserved_d = reserved_q - ONE_C;
            default: reserved_d = reserved_q;
        endcase

        if (beat_drop_s | issue_viol_s) begin
            drop_err_d = 1'b1;
        end else if (clr_err) begin
            drop_err_d = 1'b0;
        end else begin
            drop_err_d = drop_err_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {(PTR_W+1){1'b0}};
            reserved_q <= {(PTR_W+1){1'b0}};
            drop_err_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            reserved_q <= reserved_d;
            drop_err_q <= drop_err_d;
        end
    end

    alu_rsp_mem #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_data_s),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data_s)
    );

    alu_result_buffer_chk #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .count     (count_q),
        .reserved  (reserved_q),
        .out_valid (out_valid_s),
        .pop       (pop_s),
        .drop_err  (drop_err_q)
    );

    assign out_if.out_valid  = out_valid_s;
    assign out_if.out_result = rd_data_s[DATA_W-1:0];
    assign out_if.out_flags  = rd_data_s[DATA_W +: FLAG_W];
    assign credit_ok         = credit_ok_s;
    assign count             = count_q;
    assign drop_err          = drop_err_q;
endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer with a two-stage behavioural ALU in front of it.
module tb_alu_result_buffer;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        issue_fire;
    logic        alu_valid;
    logic [15:0] alu_result;
    logic        alu_zero, alu_negative, alu_overflow;
    logic        credit_ok;
    logic [3:0]  count;
    logic        drop_err;
    logic        clr_err;

    alu_result_buffer_if #(.DATA_W(16)) out_if ();

    alu_result_buffer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_fire   (issue_fire),
        .alu_valid    (alu_valid),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_negative (alu_negative),
        .alu_overflow (alu_overflow),
        .credit_ok    (credit_ok),
        .out_if       (out_if),
        .count        (count),
        .drop_err     (drop_err),
        .clr_err      (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream ALU model: result packed as {V, N, Z, result}.
    function automatic logic [18:0] alu_f(input alu_op_e op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic        v;
        v = 1'b0;
        case (op)
            OP_ADD: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
            OP_SUB: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_SHL: r = a << b[3:0];
            OP_SHR: r = a >> b[3:0];
            OP_SLT: r = ($signed(a) < $signed(b)) ? 16'h0001 : 16'h0000;
            default: r = 16'h0000;
        endcase
        return {v, r[15], (r == 16'h0000), r};
    endfunction

    logic        in_v;
    alu_op_e     in_op;
    logic [15:0] in_a, in_b;
    logic        s1_v, s2_v;
    logic [18:0] s1_d, s2_d;
    logic        inj_v;
    logic [18:0] inj_d;

    // Two-stage ALU pipeline, reset on the same rst_n as the buffer.
    always @(posedge clk) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            s1_v <= in_v;
            s1_d <= alu_f(in_op, in_a, in_b);
            s2_v <= s1_v;
            s2_d <= s1_d;
        end
    end

    logic [18:0] beat_s;
    assign beat_s       = inj_v ? inj_d : s2_d;
    assign alu_valid    = s2_v | inj_v;
    assign alu_result   = beat_s[15:0];
    assign alu_zero     = beat_s[16];
    assign alu_negative = beat_s[17];
    assign alu_overflow = beat_s[18];

    logic [18:0] popq[$];

    // Record every accepted beat just before the edge that pops it.
    always @(negedge clk) begin
        if (rst_n && out_if.out_valid && out_if.out_ready) begin
            popq.push_back({out_if.out_flags, out_if.out_result});
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input alu_op_e op, input logic [15:0] a, input logic [15:0] b);
        issue_fire = 1'b1;
        in_v = 1'b1; in_op = op; in_a = a; in_b = b;
        step();
        issue_fire = 1'b0;
        in_v = 1'b0;
    endtask

    task automatic wait_count(input logic [3:0] target);
        for (int t = 0; t < 20 && count != target; t++) step();
    endtask

    logic [18:0] expq[$];
    logic [18:0] drain_exp [9];

    initial begin
        rst_n = 1'b0; issue_fire = 1'b0; clr_err = 1'b0; out_if.out_ready = 1'b0;
        in_v = 1'b0; in_op = OP_ADD; in_a = 16'h0000; in_b = 16'h0000;
        inj_v = 1'b0; inj_d = 19'h00000;

        // Reset then idle.
        step(); step();
        rst_n = 1'b1;
        step();
        chk("rst_out_valid", 32'(out_if.out_valid), 32'd0);
        chk("rst_credit_ok", 32'(credit_ok), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_drop_err", 32'(drop_err), 32'd0);

        // Three back-to-back ops with the consumer always ready.
        out_if.out_ready = 1'b1;
        issue(OP_ADD, 16'h1234, 16'h5678);
        issue(OP_SUB, 16'h8000, 16'h0001);
        issue(OP_AND, 16'hFF00, 16'h0FF0);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("pass_count_le1", 32'(count <= 4'd1), 32'd1);
        end
        chk("pass_n", 32'(popq.size()), 32'd3);
        if (popq.size() == 3) begin
            chk("pass_add", 32'(popq[0]), 32'h068AC);
            chk("pass_sub", 32'(popq[1]), 32'h47FFF);
            chk("pass_and", 32'(popq[2]), 32'h00F00);
        end
        popq.delete();

        // Fill with eight ops while the consumer stalls.
        out_if.out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("fill_credit_ok", 32'(credit_ok), 32'd1);
            issue(OP_OR, 16'(16'h0100 + k), 16'h0000);
        end
        chk("fill_credit_out", 32'(credit_ok), 32'd0);
        wait_count(4'd8);
        chk("fill_count", 32'(count), 32'd8);

        // Issue without credit: flagged, not counted.
        issue_fire = 1'b1; step(); issue_fire = 1'b0;
        chk("viol_drop_err", 32'(drop_err), 32'd1);
        chk("viol_reserved", 32'(dut.reserved_q), 32'd8);
        clr_err = 1'b1; step(); clr_err = 1'b0;
        chk("clr_drop_err", 32'(drop_err), 32'd0);

        // Beat arriving at a full buffer with no pop is lost.
        inj_v = 1'b1; inj_d = 19'h0DEAD; step(); inj_v = 1'b0;
        chk("full_drop_err", 32'(drop_err), 32'd1);
        chk("full_drop_count", 32'(count), 32'd8);

        // Set wins over clear in the same cycle.
        clr_err = 1'b1; step();
        chk("clr_still_low", 32'(drop_err), 32'd0);
        issue_fire = 1'b1; step(); issue_fire = 1'b0; clr_err = 1'b0;
        chk("set_dominates", 32'(drop_err), 32'd1);
        clr_err = 1'b1; step(); clr_err = 1'b0;
        chk("clr_again", 32'(drop_err), 32'd0);

        // Single pop returns exactly one credit.
        out_if.out_ready = 1'b1; step(); out_if.out_ready = 1'b0;
        chk("pop1_count", 32'(count), 32'd7);
        chk("pop1_credit_ok", 32'(credit_ok), 32'd1);
        chk("pop1_n", 32'(popq.size()), 32'd1);
        if (popq.size() == 1) chk("pop1_head", 32'(popq[0]), 32'h00100);
        popq.delete();

        // Refill to full through the ALU.
        issue(OP_XOR, 16'hAAAA, 16'h5555);
        wait_count(4'd8);
        chk("refill_count", 32'(count), 32'd8);
        chk("refill_credit", 32'(credit_ok), 32'd0);

        // Push and pop together while full; the rejected issue also flags an error.
        inj_v = 1'b1; inj_d = 19'h5BEEF; issue_fire = 1'b1; out_if.out_ready = 1'b1;
        step();
        inj_v = 1'b0; issue_fire = 1'b0;
        chk("pp_count", 32'(count), 32'd8);
        chk("pp_drop_err", 32'(drop_err), 32'd1);
        wait_count(4'd0);
        out_if.out_ready = 1'b0;
        for (int k = 0; k < 7; k++) drain_exp[k] = 19'(19'h00101 + k);
        drain_exp[7] = 19'h2FFFF;
        drain_exp[8] = 19'h5BEEF;
        chk("drain_n", 32'(popq.size()), 32'd9);
        for (int k = 0; k < 9 && k < popq.size(); k++) chk("drain_order", 32'(popq[k]), 32'(drain_exp[k]));
        popq.delete();

        // Clean restart, then 20 beats across the pointer wrap.
        rst_n = 1'b0; step(); step(); rst_n = 1'b1;
        out_if.out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            chk("wrap_credit", 32'(credit_ok), 32'd1);
            if (k % 2 == 0) issue(OP_XOR, 16'hAAAA, 16'h5555);
            else            issue(OP_SLT, 16'hFFFF, 16'h0001);
        end
        for (int k = 0; k < 5; k++) step();
        chk("wrap_n", 32'(popq.size()), 32'd20);
        for (int k = 0; k < 20 && k < popq.size(); k++)
            chk("wrap_beat", 32'(popq[k]), (k % 2 == 0) ? 32'h2FFFF : 32'h00001);
        chk("wrap_drop_err", 32'(drop_err), 32'd0);
        popq.delete();

        // Reset held for two cycles with beats stored and in flight.
        out_if.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) issue(OP_ADD, 16'(k), 16'h0001);
        rst_n = 1'b0; step(); step(); rst_n = 1'b1;
        step();
        chk("mid_rst_valid", 32'(out_if.out_valid), 32'd0);
        chk("mid_rst_credit", 32'(credit_ok), 32'd1);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_drop", 32'(drop_err), 32'd0);
        step(); step(); step();
        chk("mid_rst_quiet", 32'(count), 32'd0);

        // Randomised consumer against a scoreboard.
        begin
            int issued;
            int cyc;
            issued = 0;
            cyc = 0;
            while (issued < 1000 && cyc < 20000) begin
                out_if.out_ready = 1'($urandom_range(0, 1));
                if (credit_ok) begin
                    in_op = alu_op_e'($urandom_range(0, 7));
                    in_a  = 16'($urandom);
                    in_b  = 16'($urandom);
                    expq.push_back(alu_f(in_op, in_a, in_b));
                    issue_fire = 1'b1; in_v = 1'b1;
                    issued++;
                end
                step();
                issue_fire = 1'b0; in_v = 1'b0;
                cyc++;
            end
            chk("rand_issued", 32'(issued), 32'd1000);
        end
        out_if.out_ready = 1'b1;
        for (int t = 0; t < 100 && popq.size() < expq.size(); t++) step();
        out_if.out_ready = 1'b0;
        chk("rand_n", 32'(popq.size()), 32'(expq.size()));
        for (int k = 0; k < expq.size() && k < popq.size(); k++)
            chk("rand_beat", 32'(popq[k]), 32'(expq[k]));
        chk("rand_drop_err", 32'(drop_err), 32'd0);
        chk("rand_count", 32'(count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
Downstream stage of alu_pipeline. Captures every result and flag beat from the ALU, which has no stall input, into a DEPTH-entry first-word-fall-through FIFO. It presents the beats to a consumer over a valid/ready handshake. It also runs a credit counter, giving the upstream issue logic a credit_ok signal so that results already in flight can never overflow the buffer.

Parameters:
DATA_W, 16, width of alu_result / out_result
DEPTH, 8, FIFO entries and total credits; power of two, at least 2
PTR_W, $clog2(DEPTH), derived localparam, not overridable

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
issue_fire  input  1  high in the cycle upstream drives valid_in=1 into alu_pipeline
alu_valid  input  1  alu_pipeline valid_out
alu_result  input  DATA_W  alu_pipeline result
alu_zero  input  1  alu_pipeline zero
alu_negative  input  1  alu_pipeline negative
alu_overflow  input  1  alu_pipeline overflow
credit_ok  output  1  upstream may issue this cycle
out_valid  output  1  head entry available
out_ready  input  1  consumer accepts head
out_result  output  DATA_W  head result
out_flags  output  3  head flags {overflow, negative, zero}
count  output  PTR_W+1  stored entries, 0..DEPTH
drop_err  output  1  sticky protocol-violation flag
clr_err  input  1  clears drop_err

Behaviour:
- One clock; reset is synchronous and active-low. All state updates on the rising edge of clk.
- Reset (rst_n=0 at an edge), including mid-operation:
  - wr_ptr, rd_ptr, count, reserved and drop_err go to 0.
  - Consequences: out_valid=0, credit_ok=1.
  - Storage contents are don't-care.
  - In-flight ALU beats arriving after reset are dropped; the ALU itself is reset on the same rst_n.
- push = alu_valid.
- pop = out_valid & out_ready.
- FIFO is first-word-fall-through:
  - out_valid = (count != 0).
  - out_result and out_flags = mem[rd_ptr], driven combinationally from registered state.
  - Both are held stable while out_valid=1 and out_ready=0.
- Latency: a beat pushed at edge N makes out_valid=1 after edge N, i.e. visible in cycle N+1. No same-cycle bypass.
- Empty with push: the entry is written; no pop is possible that cycle.
- Full (count==DEPTH):
  - push with pop: both happen, count stays DEPTH, pointers advance.
  - push without pop: beat discarded, drop_err set to 1, pointers and count unchanged.
- Pointers wrap modulo DEPTH.
- count changes by +1 on push only, -1 on pop only, and is unchanged on both or neither.
- Credits:
  - reserved (PTR_W+1 bits) = entries stored + ops in flight.
  - Next value: reserved + issue_fire_accepted - pop.
  - credit_ok = (reserved < DEPTH), combinational from the register.
  - issue_fire with credit_ok=0 is a violation: not counted, drop_err set to 1.
  - issue_fire and pop in the same cycle with reserved==DEPTH: credit_ok is still 0, so the issue is rejected. No combinational credit return.
- drop_err:
  - Set dominates clr_err in the same cycle.
  - Otherwise clr_err=1 clears it at the next edge.
- Pipeline latency is irrelevant to correctness: credits are returned only on pop, never on push.
- Assertions (sim only):
  - count <= DEPTH.
  - reserved >= count.
  - No pop when out_valid=0.

Decomposition:
- Shared package alu_pkg holds:
  - ALU_DATA_W=16.
  - Op encodings ADD=000, SUB=001, AND=010, OR=011, XOR=100, SHL=101, SHR=110, SLT=111.
  - Flag bit indices FLAG_Z=0, FLAG_N=1, FLAG_V=2.
- One sub-module alu_rsp_mem: DEPTH x (DATA_W+3) register array, write port plus asynchronous read port.
- Pointer, count and credit logic stay in the top module.

Test Plan:
- Reset then idle -> out_valid=0, credit_ok=1, count=0, drop_err=0; hold rst_n=0 for 2 cycles mid-traffic -> same values the cycle after release.
- Through alu_pipeline:
  - Issue ADD 1234+5678, SUB 8000-0001, AND FF00&0FF0 back-to-back with out_ready=1.
  - Required in order: 68AC flags 000; 7FFF flags 100; 0F00 flags 000.
  - count never exceeds 1.
- out_ready=0, issue 8 ops -> credit_ok falls to 0 after the 8th issue_fire; count reaches 8. Then out_ready=1 for one cycle -> exactly one pop, count=7, credit_ok=1 on the next cycle.
- Full FIFO, push and pop in the same cycle -> count stays 8, popped head equals oldest entry, new beat appears last; order preserved across pointer wrap, checked with 20 sequential XOR AAAA^5555=FFFF and SLT FFFF<0001=0001 beats.
- Violation checks:
  - Force issue_fire=1 while credit_ok=0 -> drop_err=1 next cycle, reserved unchanged.
  - Inject alu_valid while count=8 and out_ready=0 -> beat lost, drop_err=1.
  - clr_err pulse -> drop_err=0.
- Randomized out_ready (50%) for 1000 issues against a scoreboard -> zero mismatches, drop_err stays 0.
